// File: rtl/char_fill_arbiter_pkg.sv
// Shared constants and types for the character console fill arbiter.
// Covers screen geometry, bus windows, register offsets, the op and state enums, and helpers.
package char_fill_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = 12;

  localparam logic [AW-1:0] COLS_W  = AW'(COLS);
  localparam logic [AW-1:0] CELLS_W = AW'(CELLS);

  localparam logic [1:0] WIN_CHAR = 2'b01;
  localparam logic [1:0] WIN_REG  = 2'b11;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_FILL   = 2'd1;
  localparam logic [1:0] REG_START  = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam logic [15:0] FILL_RESET = 16'h0720;

  typedef enum logic [1:0] {
    OP_ABORT        = 2'd0,
    OP_CLEAR_SCREEN = 2'd1,
    OP_CLEAR_ROW    = 2'd2,
    OP_RANGE        = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [AW-1:0] row_base(input logic [4:0] row);
    return AW'(row) * COLS_W;
  endfunction

endpackage

// File: rtl/char_fill_arbiter_if.sv
// Bus and char RAM write-port signals of the fill arbiter.
// The master side is the CPU/RAM environment; the slave side is the arbiter.
interface char_fill_arbiter_if;
  import char_fill_pkg::*;

  logic [31:0]   a;
  logic [31:0]   d;
  logic          we;
  logic [31:0]   spo;
  logic [AW-1:0] fb_a;
  logic [15:0]   fb_d;
  logic          fb_we;
  logic          irq;

  modport master (output a, d, we, input spo, fb_a, fb_d, fb_we, irq);
  modport slave  (input a, d, we, output spo, fb_a, fb_d, fb_we, irq);

endinterface

// File: rtl/char_fill_arbiter_engine.sv
// Fill engine: command acceptance, FSM and cur/remaining counters.
// Offers one cell per cycle on addr/valid unless the CPU claims the port via yield.
//
//  state  | meaning
//  S_IDLE | no fill in progress, commands accepted
//  S_RUN  | writing cells, one per non-yielded cycle
//  S_DONE | one-cycle tail that raises done
module char_fill_engine
  import char_fill_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  input  op_e           cmd_op,
  input  logic [4:0]    cmd_row,
  input  logic [AW-1:0] start,
  input  logic [AW-1:0] count,
  input  logic          yield,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic          busy,
  output logic          err,
  output logic          done,
  output logic          finish
);

  state_e        state, state_nxt;
  logic [AW-1:0] cur, cur_nxt, rem, rem_nxt;
  logic [AW-1:0] load_cur, load_rem;
  logic          load_bad, err_nxt, done_nxt;

  always_comb begin
    load_cur = '0;
    load_rem = '0;
    load_bad = 1'b0;
    case (cmd_op)
      OP_CLEAR_SCREEN: load_rem = CELLS_W;
      OP_CLEAR_ROW: begin
        load_bad = (cmd_row >= 5'(ROWS));
        load_cur = row_base(cmd_row);
        load_rem = COLS_W;
      end
      OP_RANGE: begin
        load_bad = (start >= CELLS_W);
        load_cur = start;
        load_rem = (count < (CELLS_W - start)) ? count : (CELLS_W - start);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    rem_nxt   = rem;
    err_nxt   = err;
    done_nxt  = done;
    valid     = 1'b0;
    case (state)
      S_RUN: begin
        if (!yield) begin
          valid   = 1'b1;
          rem_nxt = rem - 1'b1;
          // cur parks on the last cell written so it never passes CELLS-1
          if (rem == AW'(1)) state_nxt = S_DONE;
          else               cur_nxt   = cur + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end
      default: ;
    endcase
    if (cmd_valid) begin
      if (cmd_op == OP_ABORT) begin
        state_nxt = S_IDLE;
        valid     = 1'b0;
        cur_nxt   = cur;
        rem_nxt   = '0;
        err_nxt   = 1'b0;
      end else if (state != S_IDLE || load_bad) begin
        err_nxt = 1'b1;
      end else begin
        cur_nxt   = load_cur;
        rem_nxt   = load_rem;
        done_nxt  = 1'b0;
        state_nxt = (load_rem == '0) ? S_DONE : S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cur   <= '0;
      rem   <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      rem   <= rem_nxt;
      err   <= err_nxt;
      done  <= done_nxt;
    end
  end

  assign addr   = cur;
  assign busy   = (state != S_IDLE);
  assign finish = (state == S_DONE);

endmodule

// File: rtl/char_fill_arbiter.sv
// Char RAM write-port owner: CPU writes pass through with priority, the fill engine uses idle cycles.
// Define CHAR_FILL_IRQ_EN to add the fill-done interrupt flop; otherwise irq is tied low.
module char_fill_arbiter
  import char_fill_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  char_fill_arbiter_if.slave bus
);

  logic [31:0]   wdata, rdata;
  logic          sel_char, sel_reg, reg_we, reg_rd, cmd_valid, abort;
  logic [1:0]    reg_idx;
  logic [15:0]   fill_word;
  logic [AW-1:0] start_r, count_r;
  logic          eng_valid, eng_busy, eng_err, eng_done, eng_finish;
  logic [AW-1:0] eng_addr;
  logic          fb_we_nxt;
  logic [AW-1:0] fb_a_nxt;
  logic [15:0]   fb_d_nxt;
  logic          unused_bits;

  assign wdata     = swap32(bus.d);
  assign reg_idx   = bus.a[3:2];
  assign sel_char  = bus.we && (bus.a[23:22] == WIN_CHAR);
  assign sel_reg   = (bus.a[23:22] == WIN_REG);
  assign reg_we    = sel_reg && bus.we;
  assign reg_rd    = sel_reg && !bus.we;
  assign cmd_valid = reg_we && (reg_idx == REG_CMD);
  assign abort     = cmd_valid && (wdata[1:0] == OP_ABORT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_word <= FILL_RESET;
      start_r   <= '0;
      count_r   <= '0;
    end else if (reg_we) begin
      case (reg_idx)
        REG_FILL:  fill_word <= wdata[15:0];
        REG_START: start_r   <= wdata[AW-1:0];
        REG_COUNT: count_r   <= wdata[AW-1:0];
        default: ;
      endcase
    end
  end

  char_fill_engine u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (op_e'(wdata[1:0])),
    .cmd_row   (wdata[12:8]),
    .start     (start_r),
    .count     (count_r),
    .yield     (sel_char),
    .valid     (eng_valid),
    .addr      (eng_addr),
    .busy      (eng_busy),
    .err       (eng_err),
    .done      (eng_done),
    .finish    (eng_finish)
  );

  always_comb begin
    fb_we_nxt = 1'b0;
    fb_a_nxt  = bus.fb_a;
    fb_d_nxt  = bus.fb_d;
    if (sel_char) begin
      fb_we_nxt = 1'b1;
      fb_a_nxt  = bus.a[13:2];
      fb_d_nxt  = wdata[15:0];
    end else if (eng_valid) begin
      fb_we_nxt = 1'b1;
      fb_a_nxt  = eng_addr;
      fb_d_nxt  = fill_word;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_STATUS: rdata = {eng_busy, eng_err, eng_done, 17'd0, eng_addr};
      REG_FILL:   rdata = {16'd0, fill_word};
      REG_START:  rdata = {20'd0, start_r};
      REG_COUNT:  rdata = {20'd0, count_r};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.fb_we <= 1'b0;
      bus.fb_a  <= '0;
      bus.fb_d  <= '0;
      bus.spo   <= '0;
    end else begin
      bus.fb_we <= fb_we_nxt;
      bus.fb_a  <= fb_a_nxt;
      bus.fb_d  <= fb_d_nxt;
      if (reg_rd) bus.spo <= swap32(rdata);
    end
  end

`ifdef CHAR_FILL_IRQ_EN
  logic irq_r;

  // a completion in the same cycle as a STATUS read wins so it is never lost
  always_ff @(posedge clk) begin
    if (!rst_n)                                            irq_r <= 1'b0;
    else if (eng_finish)                                   irq_r <= 1'b1;
    else if ((reg_rd && reg_idx == REG_STATUS) || abort)   irq_r <= 1'b0;
  end

  assign bus.irq     = irq_r;
  assign unused_bits = ^{bus.a[31:24], bus.a[21:14], bus.a[1:0], wdata[31:16]};
`else
  assign bus.irq     = 1'b0;
  assign unused_bits = ^{bus.a[31:24], bus.a[21:14], bus.a[1:0], wdata[31:16], eng_finish, abort};
`endif

endmodule

// File: tb/tb_char_fill_arbiter.sv
// Directed bench for char_fill_arbiter: reset, fills, CPU priority, range clipping, rejects, abort.
module tb_char_fill_arbiter;

  localparam logic [31:0] CHAR_BASE = 32'h0040_0000;
  localparam logic [31:0] REG_BASE  = 32'h00C0_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  char_fill_arbiter_if bus();

  char_fill_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [1:0] idx, input logic [31:0] val);
    bus.a  = REG_BASE | {28'd0, idx, 2'b00};
    bus.d  = bswap(val);
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
    bus.a  = '0;
    bus.d  = '0;
  endtask

  task automatic rd_reg(input logic [1:0] idx, output logic [31:0] val);
    bus.a  = REG_BASE | {28'd0, idx, 2'b00};
    bus.we = 1'b0;
    tick();
    val   = bswap(bus.spo);
    bus.a = '0;
  endtask

  // Runs ncyc edges, expecting engine writes at first, first+1, ... carrying data
  task automatic run_fill(input int ncyc, input logic [11:0] first, input logic [15:0] data,
                          output int nwr, output int nbad, output int last);
    logic [11:0] exp_a;
    nwr  = 0;
    nbad = 0;
    last = 0;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      if (bus.fb_we) begin
        exp_a = first + 12'(nwr);
        if (bus.fb_a !== exp_a || bus.fb_d !== data) nbad++;
        nwr++;
        last = k;
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] cpu_val;
    int nwr, nbad, last, ncpu, cpu_bad;

    bus.a  = '0;
    bus.d  = '0;
    bus.we = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    check("rst_fb_we", {31'd0, bus.fb_we}, 32'd0);
    check("rst_fb_a", {20'd0, bus.fb_a}, 32'd0);
    check("rst_fb_d", {16'd0, bus.fb_d}, 32'd0);
    check("rst_spo", bus.spo, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    rd_reg(2'd0, v); check("rst_status", v, 32'h0000_0000);
    rd_reg(2'd1, v); check("rst_fill", v, 32'h0000_0720);
    rd_reg(2'd2, v); check("rst_start", v, 32'd0);
    rd_reg(2'd3, v); check("rst_count", v, 32'd0);

    // full-screen clear
    wr_reg(2'd1, 32'h0000_1F41);
    rd_reg(2'd1, v); check("fill_readback", v, 32'h0000_1F41);
    wr_reg(2'd0, 32'h0000_0001);
    run_fill(2405, 12'd0, 16'h1F41, nwr, nbad, last);
    check("cls_writes", nwr, 32'd2400);
    check("cls_bad", nbad, 32'd0);
    check("cls_last_edge", last, 32'd2400);
`ifdef CHAR_FILL_IRQ_EN
    check("cls_irq_set", {31'd0, bus.irq}, 32'd1);
`else
    check("cls_irq_tied", {31'd0, bus.irq}, 32'd0);
`endif
    rd_reg(2'd0, v); check("cls_status", v, 32'h2000_095F);
    check("cls_irq_after_read", {31'd0, bus.irq}, 32'd0);

    // clear last row, then reject row 30
    wr_reg(2'd0, 32'h0000_1D02);
    run_fill(90, 12'd2320, 16'h1F41, nwr, nbad, last);
    check("row29_writes", nwr, 32'd80);
    check("row29_bad", nbad, 32'd0);
    check("row29_last_edge", last, 32'd80);
    wr_reg(2'd0, 32'h0000_1E02);
    run_fill(10, 12'd0, 16'h1F41, nwr, nbad, last);
    check("row30_writes", nwr, 32'd0);
    rd_reg(2'd0, v); check("row30_status", v, 32'h6000_095F);
    wr_reg(2'd0, 32'h0000_0000);
    rd_reg(2'd0, v); check("abort_idle_status", v, 32'h2000_095F);

    // row 2 fill with a CPU write to cell 5 on every third edge
    wr_reg(2'd0, 32'h0000_0202);
    ncpu = 0; cpu_bad = 0; nwr = 0; nbad = 0; last = 0;
    for (int k = 1; k <= 130; k++) begin
      cpu_val = 16'h4100 + 16'(k);
      if ((k % 3 == 1) && (k <= 120)) begin
        bus.a  = CHAR_BASE | (32'd5 << 2);
        bus.d  = bswap({16'd0, cpu_val});
        bus.we = 1'b1;
      end else begin
        bus.a  = '0;
        bus.d  = '0;
        bus.we = 1'b0;
      end
      tick();
      if ((k % 3 == 1) && (k <= 120)) begin
        ncpu++;
        if (!(bus.fb_we === 1'b1 && bus.fb_a === 12'd5 && bus.fb_d === cpu_val)) cpu_bad++;
      end else if (bus.fb_we) begin
        if (bus.fb_a !== 12'(160 + nwr) || bus.fb_d !== 16'h1F41) nbad++;
        nwr++;
        last = k;
      end
    end
    bus.we = 1'b0;
    bus.a  = '0;
    bus.d  = '0;
    check("cpu_writes", ncpu, 32'd40);
    check("cpu_landed_bad", cpu_bad, 32'd0);
    check("cpu_engine_writes", nwr, 32'd80);
    check("cpu_engine_bad", nbad, 32'd0);
    check("cpu_engine_last_edge", last, 32'd120);
    rd_reg(2'd0, v); check("cpu_status", v, 32'h2000_00EF);

    // range clipped at end of screen, then zero-length range
    wr_reg(2'd2, 32'd2390);
    wr_reg(2'd3, 32'd50);
    wr_reg(2'd0, 32'h0000_0003);
    run_fill(15, 12'd2390, 16'h1F41, nwr, nbad, last);
    check("range_writes", nwr, 32'd10);
    check("range_bad", nbad, 32'd0);
    check("range_last_edge", last, 32'd10);
    rd_reg(2'd0, v); check("range_status", v, 32'h2000_095F);
    wr_reg(2'd3, 32'd0);
    wr_reg(2'd0, 32'h0000_0003);
    rd_reg(2'd0, v); check("range0_in_done", v, 32'h8000_0956);
    rd_reg(2'd0, v); check("range0_status", v, 32'h2000_0956);
    run_fill(5, 12'd0, 16'h1F41, nwr, nbad, last);
    check("range0_writes", nwr, 32'd0);

    // command while busy, then abort
    wr_reg(2'd0, 32'h0000_0001);
    run_fill(5, 12'd0, 16'h1F41, nwr, nbad, last);
    check("busy_pre_writes", nwr, 32'd5);
    wr_reg(2'd0, 32'h0000_0001);
    rd_reg(2'd0, v); check("busy_reject_status", v, 32'hC000_0006);
    check("busy_fill_continues", {19'd0, bus.fb_we, bus.fb_a}, {19'd0, 1'b1, 12'd6});
    wr_reg(2'd0, 32'h0000_0000);
    check("abort_no_write", {31'd0, bus.fb_we}, 32'd0);
    tick();
    check("abort_no_write2", {31'd0, bus.fb_we}, 32'd0);
    rd_reg(2'd0, v); check("abort_status", v, 32'h0000_0007);

    // reset in the middle of a fill
    wr_reg(2'd0, 32'h0000_0001);
    run_fill(20, 12'd0, 16'h1F41, nwr, nbad, last);
    rst_n = 1'b0;
    tick();
    check("midrst_fb_we", {31'd0, bus.fb_we}, 32'd0);
    check("midrst_fb_a", {20'd0, bus.fb_a}, 32'd0);
    check("midrst_spo", bus.spo, 32'd0);
    rst_n = 1'b1;
    rd_reg(2'd0, v); check("midrst_status", v, 32'h0000_0000);
    rd_reg(2'd1, v); check("midrst_fill", v, 32'h0000_0720);
    run_fill(5, 12'd0, 16'h0720, nwr, nbad, last);
    check("midrst_idle_writes", nwr, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
